// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_arbiter
//  Purpose  : Two requesters share one 8-bit left shifter (amount 0-8, fill
//             bit). A round-robin arbiter picks one request, a three-state FSM
//             accepts, computes and hands off the result on a tagged channel.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [7:0]       i_req0_data,
   input  logic [3:0]       i_req0_amt,
   input  logic             i_req0_fill,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [7:0]       i_req1_data,
   input  logic [3:0]       i_req1_amt,
   input  logic             i_req1_fill,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [7:0]       o_res_data,
   output logic             o_res_id,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_done_count
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_prio;        // requester that wins a tie (1 = requester 1)
   logic [7:0]       r_op_data;
   logic [3:0]       r_op_amt;
   logic             r_op_fill;
   logic             r_op_id;
   logic             r_res_valid;
   logic [7:0]       r_res_data;
   logic             r_res_id;
   logic [CNT_W-1:0] r_done_count;

   logic             w_idle;
   logic             w_any_valid;
   logic             w_grant_id;
   logic             w_accept;
   logic [7:0]       w_sel_data;
   logic [3:0]       w_sel_amt;
   logic             w_sel_fill;
   logic [15:0]      w_shift_ext;
   logic [7:0]       w_shift_res;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_any_valid = i_req0_valid | i_req1_valid;
   // A lone requester always wins; on a tie the priority pointer decides.
   assign w_grant_id  = (i_req0_valid & i_req1_valid) ? r_prio : i_req1_valid;
   assign w_accept    = w_idle & w_any_valid & ~i_rst;

   assign o_req0_ready = w_accept & ~w_grant_id;
   assign o_req1_ready = w_accept &  w_grant_id;

   assign w_sel_data = w_grant_id ? i_req1_data : i_req0_data;
   assign w_sel_amt  = w_grant_id ? i_req1_amt  : i_req0_amt;
   assign w_sel_fill = w_grant_id ? i_req1_fill : i_req0_fill;

   // Shifting {data, 8 x fill} left and keeping the upper byte covers
   // amounts 0..8 in one expression; larger amounts pass the data through.
   assign w_shift_ext = {r_op_data, {8{r_op_fill}}} << r_op_amt;
   assign w_shift_res = (r_op_amt > 4'd8) ? r_op_data : w_shift_ext[15:8];

   assign o_res_valid  = r_res_valid;
   assign o_res_data   = r_res_data;
   assign o_res_id     = r_res_id;
   assign o_busy       = ~w_idle;
   assign o_done_count = r_done_count;

   // Sequencer: accept in IDLE, compute in SHIFT, hold result until handshake.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_prio       <= 1'b0;
         r_op_data    <= 8'h00;
         r_op_amt     <= 4'h0;
         r_op_fill    <= 1'b0;
         r_op_id      <= 1'b0;
         r_res_valid  <= 1'b0;
         r_res_data   <= 8'h00;
         r_res_id     <= 1'b0;
         r_done_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_valid) begin
                  r_op_data <= w_sel_data;
                  r_op_amt  <= w_sel_amt;
                  r_op_fill <= w_sel_fill;
                  r_op_id   <= w_grant_id;
                  r_prio    <= ~w_grant_id;
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_res_data  <= w_shift_res;
               r_res_id    <= r_op_id;
               r_res_valid <= 1'b1;
               r_state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (i_res_ready) begin
                  r_res_valid  <= 1'b0;
                  r_done_count <= r_done_count + 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_res_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_arbiter
//  Purpose  : Self-checking bench for shift_arbiter against a transaction-level
//             reference model (arbitration, shift arithmetic, latency, count).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

   logic       clk;
   logic       rst;
   logic       v0, v1, f0, f1, rr;
   logic [7:0] d0, d1;
   logic [3:0] a0, a1;

   logic       r0, r1, valid, res_id, busy;
   logic [7:0] res_data;
   logic [7:0] cnt;
   logic       r0_b, r1_b, valid_b, id_b, busy_b;
   logic [7:0] data_b;
   logic [1:0] cnt2;

   int chk;
   int err;
   int cyc;

   // reference model state
   bit         m_inflight;
   int         m_age;
   int         m_last;
   logic [7:0] m_res;
   logic       m_id;
   int         m_count;

   // expectations for the current cycle
   logic e_r0, e_r1, e_valid, e_busy;

   shift_arbiter u_dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_data(d0), .i_req0_amt(a0), .i_req0_fill(f0),
      .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_data(d1), .i_req1_amt(a1), .i_req1_fill(f1),
      .o_res_valid(valid), .i_res_ready(rr), .o_res_data(res_data), .o_res_id(res_id),
      .o_busy(busy), .o_done_count(cnt)
   );

   shift_arbiter #(.CNT_W(2)) u_dut_w2 (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(v0), .o_req0_ready(r0_b), .i_req0_data(d0), .i_req0_amt(a0), .i_req0_fill(f0),
      .i_req1_valid(v1), .o_req1_ready(r1_b), .i_req1_data(d1), .i_req1_amt(a1), .i_req1_fill(f1),
      .o_res_valid(valid_b), .i_res_ready(rr), .o_res_data(data_b), .o_res_id(id_b),
      .o_busy(busy_b), .o_done_count(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic statement of the shift rule
   function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] amt, input logic fill);
      int r;
      int n;
      n = int'(amt);
      if (n == 0 || n > 8) return d;
      if (n == 8) return fill ? 8'hFF : 8'h00;
      r = (int'(d) * (1 << n)) % 256;
      if (fill) r = r + (1 << n) - 1;
      return 8'(r);
   endfunction

   // Apply inputs, let them settle, and derive this cycle's expectations
   task automatic drive(input bit iv0, input logic [7:0] id0, input logic [3:0] ia0, input bit if0,
                        input bit iv1, input logic [7:0] id1, input logic [3:0] ia1, input bit if1,
                        input bit irr);
      int w;
      v0 = iv0; d0 = id0; a0 = ia0; f0 = if0;
      v1 = iv1; d1 = id1; a1 = ia1; f1 = if1;
      rr = irr;
      #1;
      e_r0 = 1'b0; e_r1 = 1'b0; e_valid = 1'b0; e_busy = 1'b0;
      if (rst) begin
         e_r0 = 1'b0;
      end else if (!m_inflight) begin
         if (v0 || v1) begin
            w = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
            if (w == 0) e_r0 = 1'b1;
            else        e_r1 = 1'b1;
         end
      end else begin
         e_busy  = 1'b1;
         e_valid = (m_age >= 2);
      end
   endtask

   // Clock edge: move the reference model forward
   task automatic advance();
      int w;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_inflight = 0; m_count = 0; m_last = 1;
      end else if (!m_inflight) begin
         if (e_r0 || e_r1) begin
            w          = e_r1 ? 1 : 0;
            m_last     = w;
            m_id       = e_r1;
            m_res      = (w == 1) ? ref_shift(d1, a1, f1) : ref_shift(d0, a0, f0);
            m_inflight = 1;
            m_age      = 1;
         end
      end else if (m_age >= 2 && rr) begin
         m_inflight = 0;
         m_count++;
      end else begin
         m_age++;
      end
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 1);
         advance();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive(1, 8'($urandom()), 4'($urandom()), 1, 1, 8'($urandom()), 4'($urandom()), 1, 1);
         chk++;
         if ({r0, r1} !== 2'b00) begin
            err++; $display("FAIL reset_ready got %b exp 00", {r0, r1});
         end
         advance();
      end
      rst = 1'b0;
      drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
      chk++;
      if ({r0, r1, valid, busy, res_id} !== 5'b0) begin
         err++; $display("FAIL reset_ctrl got %b exp 00000", {r0, r1, valid, busy, res_id});
      end
      chk++;
      if (res_data !== 8'h00 || cnt !== 8'h00 || cnt2 !== 2'b00) begin
         err++; $display("FAIL reset_data got data=%h cnt=%h cnt2=%h exp 00", res_data, cnt, cnt2);
      end
      advance();
   endtask

   task automatic test_single();
      int first_v;
      int n_r0;
      first_v = -1;
      n_r0    = 0;
      for (int c = 0; c < 5; c++) begin
         if (c == 0) drive(1, 8'hB5, 4'd3, 1, 0, 8'h00, 4'h0, 0, 1);
         else        drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 1);
         if (r0) n_r0++;
         if (valid && first_v < 0) first_v = c;
         chk++;
         if ({r0, r1, valid, busy} !== {e_r0, e_r1, e_valid, e_busy}) begin
            err++; $display("FAIL single_ctrl c=%0d got %b exp %b", c, {r0, r1, valid, busy}, {e_r0, e_r1, e_valid, e_busy});
         end
         if (e_valid) begin
            chk++;
            if (res_data !== 8'hAF || res_id !== 1'b0) begin
               err++; $display("FAIL single_result got %h/%b exp AF/0", res_data, res_id);
            end
         end
         advance();
      end
      chk++;
      if (n_r0 != 1 || first_v != 2) begin
         err++; $display("FAIL single_timing got ready_pulses=%0d first_valid=%0d exp 1/2", n_r0, first_v);
      end
      drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 1);
      chk++;
      if (cnt !== 8'd1) begin
         err++; $display("FAIL single_count got %0d exp 1", cnt);
      end
      advance();
   endtask

   task automatic test_amt_sweep();
      logic [7:0] exp_v;
      logic [3:0] amt;
      logic       fill;
      for (int k = 0; k < 17; k++) begin
         amt  = (k == 16) ? 4'd8 : 4'(k);
         fill = (k == 16);
         for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(0, 8'h00, 4'h0, 0, 1, 8'hB5, amt, fill, 1);
            else        drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 1);
            if (c == 2) begin
               if (amt == 4'd0 || amt > 4'd8) exp_v = 8'hB5;
               else if (amt == 4'd8)          exp_v = fill ? 8'hFF : 8'h00;
               else                           exp_v = m_res;
               chk++;
               if (valid !== 1'b1 || res_data !== exp_v || res_data !== m_res || res_id !== 1'b1) begin
                  err++; $display("FAIL sweep amt=%0d fill=%b got v=%b d=%h id=%b exp 1/%h/1", amt, fill, valid, res_data, res_id, exp_v);
               end
            end
            advance();
         end
      end
   endtask

   task automatic test_alternate();
      int g_id[$];
      int g_cy[$];
      do_reset();
      for (int c = 0; c < 18; c++) begin
         drive(1, 8'($urandom()), 4'($urandom()), 1'($urandom()), 1, 8'($urandom()), 4'($urandom()), 1'($urandom()), 1);
         if (r0) begin g_id.push_back(0); g_cy.push_back(c); end
         if (r1) begin g_id.push_back(1); g_cy.push_back(c); end
         chk++;
         if ({r0, r1, valid, busy} !== {e_r0, e_r1, e_valid, e_busy}) begin
            err++; $display("FAIL alt_ctrl c=%0d got %b exp %b", c, {r0, r1, valid, busy}, {e_r0, e_r1, e_valid, e_busy});
         end
         if (e_valid) begin
            chk++;
            if (res_id !== m_id || res_data !== m_res) begin
               err++; $display("FAIL alt_result got %b/%h exp %b/%h", res_id, res_data, m_id, m_res);
            end
         end
         advance();
      end
      chk++;
      if (g_id.size() != 6) begin
         err++; $display("FAIL alt_grants got %0d exp 6", g_id.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            chk++;
            if (g_id[i] != (i % 2) || (i > 0 && g_cy[i] - g_cy[i-1] != 3)) begin
               err++; $display("FAIL alt_order i=%0d got id=%0d cyc=%0d exp id=%0d spacing 3", i, g_id[i], g_cy[i], i % 2);
            end
         end
      end
      idle_cycles(4);
   endtask

   task automatic test_backpressure();
      int cnt_before;
      cnt_before = m_count;
      for (int c = 0; c < 13; c++) begin
         if (c == 0)       drive(0, 8'h00, 4'h0, 0, 1, 8'($urandom()), 4'($urandom_range(1, 7)), 1'($urandom()), 0);
         else if (c < 12)  drive(1, 8'($urandom()), 4'($urandom()), 1, 1, 8'($urandom()), 4'($urandom()), 1, 0);
         else              drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 1);
         if (c >= 2) begin
            chk++;
            if (valid !== 1'b1 || res_data !== m_res || res_id !== 1'b1 || {r0, r1} !== 2'b00) begin
               err++; $display("FAIL bp_hold c=%0d got v=%b d=%h id=%b rdy=%b exp 1/%h/1/00", c, valid, res_data, res_id, {r0, r1}, m_res);
            end
            chk++;
            if (cnt !== 8'(cnt_before)) begin
               err++; $display("FAIL bp_count_early c=%0d got %0d exp %0d", c, cnt, cnt_before);
            end
         end
         advance();
      end
      drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 1);
      chk++;
      if (cnt !== 8'(cnt_before + 1) || valid !== 1'b0 || busy !== 1'b0) begin
         err++; $display("FAIL bp_release got cnt=%0d v=%b busy=%b exp %0d/0/0", cnt, valid, busy, cnt_before + 1);
      end
      advance();
   endtask

   task automatic test_operand_change();
      logic [7:0] sd;
      logic [3:0] sa;
      logic       sf;
      logic [7:0] exp_v;
      sd = 8'($urandom()); sa = 4'($urandom_range(1, 7)); sf = 1'($urandom());
      exp_v = ref_shift(sd, sa, sf);
      for (int c = 0; c < 6; c++) begin
         if (c == 0)      drive(1, sd, sa, sf, 0, 8'h00, 4'h0, 0, 0);
         else if (c < 5)  drive(1, 8'($urandom()), 4'($urandom()), 1'($urandom()), 0, 8'h00, 4'h0, 0, (c == 4));
         else             drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 1);
         chk++;
         if ({r0, r1, valid, busy} !== {e_r0, e_r1, e_valid, e_busy}) begin
            err++; $display("FAIL opchg_ctrl c=%0d got %b exp %b", c, {r0, r1, valid, busy}, {e_r0, e_r1, e_valid, e_busy});
         end
         if (c >= 2 && c <= 4) begin
            chk++;
            if (res_data !== exp_v || res_id !== 1'b0) begin
               err++; $display("FAIL opchg_result c=%0d got %h/%b exp %h/0", c, res_data, res_id, exp_v);
            end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         if (c == 0) drive(0, 8'h00, 4'h0, 0, 1, 8'($urandom()), 4'($urandom()), 1'($urandom()), 0);
         else        drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0);
         if (c == 2) begin
            chk++;
            if (valid !== 1'b1) begin
               err++; $display("FAIL rstmid_pre got v=%b exp 1", valid);
            end
         end
         advance();
      end
      rst = 1'b1;
      drive(1, 8'($urandom()), 4'($urandom()), 0, 1, 8'($urandom()), 4'($urandom()), 0, 0);
      chk++;
      if ({r0, r1} !== 2'b00) begin
         err++; $display("FAIL rstmid_ready got %b exp 00", {r0, r1});
      end
      advance();
      rst = 1'b0;
      drive(1, 8'($urandom()), 4'($urandom()), 0, 1, 8'($urandom()), 4'($urandom()), 0, 0);
      chk++;
      if ({valid, busy, r0, r1} !== 4'b0010 || cnt !== 8'd0 || cnt2 !== 2'd0) begin
         err++; $display("FAIL rstmid_after got v,b,r0,r1=%b cnt=%0d cnt2=%0d exp 0010/0/0", {valid, busy, r0, r1}, cnt, cnt2);
      end
      advance();
      idle_cycles(3);
   endtask

   task automatic test_wrap();
      logic [1:0] seq [5];
      seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
      do_reset();
      for (int n = 0; n < 5; n++) begin
         drive(1, 8'($urandom()), 4'($urandom()), 1'($urandom()), 0, 8'h00, 4'h0, 0, 1);
         advance();
         idle_cycles(2);
         drive(0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 1);
         chk++;
         if (cnt2 !== seq[n] || cnt !== 8'(n + 1)) begin
            err++; $display("FAIL wrap n=%0d got cnt2=%0d cnt=%0d exp %0d/%0d", n, cnt2, cnt, seq[n], n + 1);
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom()), 4'($urandom()), 1'($urandom()),
               $urandom_range(0, 3) != 0, 8'($urandom()), 4'($urandom()), 1'($urandom()),
               $urandom_range(0, 2) != 0);
         chk++;
         if ({r0, r1, valid, busy} !== {e_r0, e_r1, e_valid, e_busy} ||
             {r0_b, r1_b, valid_b, busy_b} !== {e_r0, e_r1, e_valid, e_busy}) begin
            err++; $display("FAIL rand_ctrl c=%0d got %b/%b exp %b", c, {r0, r1, valid, busy},
                            {r0_b, r1_b, valid_b, busy_b}, {e_r0, e_r1, e_valid, e_busy});
         end
         chk++;
         if (cnt !== 8'(m_count) || cnt2 !== 2'(m_count)) begin
            err++; $display("FAIL rand_count c=%0d got %0d/%0d exp %0d", c, cnt, cnt2, m_count);
         end
         if (e_valid) begin
            chk++;
            if (res_data !== m_res || res_id !== m_id || data_b !== m_res || id_b !== m_id) begin
               err++; $display("FAIL rand_result c=%0d got %h/%b exp %h/%b", c, res_data, res_id, m_res, m_id);
            end
         end
         advance();
      end
   endtask

   initial begin
      chk = 0; err = 0; cyc = 0;
      m_inflight = 0; m_age = 0; m_last = 1; m_res = 8'h00; m_id = 1'b0; m_count = 0;
      e_r0 = 0; e_r1 = 0; e_valid = 0; e_busy = 0;
      rst = 1'b1; rr = 1'b0;
      v0 = 0; v1 = 0; d0 = 0; d1 = 0; a0 = 0; a1 = 0; f0 = 0; f1 = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_amt_sweep();
      test_alternate();
      test_backpressure();
      test_operand_change();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 8-bit left-shift function (amount 0–8, programmable fill bit) between two independent requesters. Each requester presents data, shift amount and fill bit with a valid/ready handshake. A round-robin arbiter grants one request at a time, and a three-state FSM sequences accept, compute and result hand-off. Results return on a single registered output channel tagged with the requester ID. The block sits between the requesting datapaths and their consumer, so no requester needs its own shifter.

## Interface
- CNT_W, 8, width of the completed-operation counter
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req0_valid  in  1  requester 0 has an operation pending
- o_req0_ready  out  1  requester 0 operation accepted this cycle
- i_req0_data  in  8  requester 0 operand
- i_req0_amt  in  4  requester 0 shift amount
- i_req0_fill  in  1  requester 0 fill bit
- i_req1_valid, o_req1_ready, i_req1_data, i_req1_amt, i_req1_fill: as requester 0, for requester 1
- o_res_valid  out  1  result available
- i_res_ready  in  1  consumer accepts result
- o_res_data  out  8  shifted result
- o_res_id  out  1  requester that issued the result (0/1)
- o_busy  out  1  high whenever state is not IDLE
- o_done_count  out  CNT_W  number of results handed off, wraps modulo 2^CNT_W

## Operation
- FSM states are IDLE, SHIFT and HOLD. Reset state is IDLE.
- IDLE:
  - If any valid is high, the arbiter selects a grant and asserts the matching o_reqN_ready combinationally in that cycle. All other ready outputs stay low.
  - At the edge, the block latches that requester's data, amt, fill and ID, then moves to SHIFT.
  - With no valid high, the block stays in IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted most recently wins.
  - The priority pointer resets to "requester 0 wins the tie." It updates only on an accept.
- SHIFT: one cycle. The result is computed from the latched operands and registered into o_res_data/o_res_id. o_res_valid is set. The next state is HOLD.
- Shift function (amt → result):
  - 0 → data unchanged.
  - 1–7 → data shifted left by amt, with the low amt bits equal to fill.
  - 8 → all eight bits equal to fill.
  - 9–15 → data unchanged (pass-through, not saturated).
- HOLD:
  - o_res_valid is held high. o_res_data and o_res_id are stable until the handshake.
  - On o_res_valid && i_res_ready: o_done_count increments, o_res_valid clears at the edge, and the next state is IDLE.
  - No new request is accepted in the handshake cycle.
- Requester inputs are sampled only in the IDLE accept cycle. Later changes to them do not affect an in-flight operation.
- o_reqN_ready is low in SHIFT and HOLD regardless of valid.

## Timing
- Reset values: o_req0_ready=0, o_req1_ready=0, o_res_valid=0, o_res_data=8'h00, o_res_id=0, o_busy=0, o_done_count=0, priority pointer at requester 0.
- Reset asserted in any state returns the block to IDLE in the next cycle and discards the in-flight operation. The counter is cleared. While i_rst is high, all ready outputs are 0.
- Latency: a request accepted at edge T gives o_res_valid high from the cycle after edge T+1, i.e. the second cycle after acceptance.
- Minimum initiation interval is 3 cycles per operation (accept, SHIFT, HOLD with immediate i_res_ready). Throughput drops further under consumer back-pressure.
- o_busy goes high the cycle after an accept and low the cycle after the result handshake.
- o_done_count wraps from 2^CNT_W−1 to 0 with no flag.
- i_res_ready high while o_res_valid is low has no effect.

## Test plan
- Reset, then single request: req0 data=8'hB5, amt=3, fill=1 → ready0 pulses once, o_res_data=8'hAF, o_res_id=0, o_res_valid two cycles after accept, o_done_count=1.
- Amount sweep on req1, data=8'hB5, fill=0, amt 0..15:
  - amt=0 → 8'hB5.
  - amt=8 → 8'h00.
  - amt=8 with fill=1 → 8'hFF.
  - amt 9–15 → 8'hB5.
- Both valid continuously, 6 operations → grants alternate 0,1,0,1,0,1 starting with 0 after reset. o_res_id matches. Each op takes exactly 3 cycles with i_res_ready tied high.
- Back-pressure: hold i_res_ready low for 10 cycles in HOLD → o_res_valid, o_res_data and o_res_id are stable. Both ready outputs stay 0. Count increments only on the release cycle.
- Operand change after accept: req0 changes data/amt during SHIFT/HOLD → the result reflects the values latched at accept.
- Reset mid-operation in HOLD with o_res_valid high → next cycle o_res_valid=0, o_busy=0, o_done_count=0. A subsequent tie grants requester 0. Counter wrap with CNT_W=2 → sequence 1,2,3,0.
